float8_mul_pipe: RTL and testbench
==================================

// Module: float8_mul_pipe
// PURPOSE
//   3-stage pipelined multiplier for the 8-bit minifloat used by the systolic PE datapath.
//   Sits directly upstream of the minifloat adder inside each PE: it forms a*b,
//   and the adder accumulates the product into the partial sum.
//   Format: [7] sign, [6:4] exponent e, [3:0] mantissa m.
//   Value = (h.m) * 2^(e-BIAS), where h = (e!=0). This matches the adder's hidden-bit rule.
// PARAMETERS
//   EXP_W  3  exponent width; only the default is verified
//   MAN_W  4  mantissa width; only the default is verified
//   BIAS   3  exponent bias
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  a/b are valid this cycle
//   in_ready   out  1  block accepts a/b this cycle
//   a          in   8  operand A
//   b          in   8  operand B
//   out_valid  out  1  out/out_flags are valid
//   out_ready  in   1  downstream accepts the result
//   out        out  8  product
//   out_flags  out  2  [1] overflow saturated, [0] underflow flushed (for this result)
//   sticky     out  2  OR of out_flags over all results transferred since reset or clear
//   clr_sticky in   1  synchronous clear of sticky; wins over a same-cycle set
// BEHAVIOUR
// - Reset (async assert, sync release): all stage valids = 0, out = 0, out_flags = 0, sticky = 0.
// - Advance: en = out_ready | ~out_valid; in_ready = en. All three stages advance together only when en = 1.
//   - Stall (out_valid & ~out_ready): every stage register holds, out is stable, no input is taken.
//   - Bubbles are not compressed.
// - Transfer rules: input is transferred when in_valid & in_ready; output is transferred when out_valid & out_ready.
// - Latency: 3 enabled cycles from input transfer to out_valid. Throughput is 1 result per cycle when never stalled.
// - S1 (unpack): register sign s = a[7]^b[7], ea, eb, and significands Sa = {h,m}, Sb = {h,m} (5 bits each).
//   Set zero flag z if either operand has e==0 and m==0.
// - S2 (multiply): P = Sa*Sb (10 bits, binary point between P[8] and P[7]).
//   Signed exponent er = ea + eb - BIAS (6-bit signed). Carry s and z.
// - S3 (normalise and pack):
//   - if P[9]: P >>= 1, er += 1
//   - else: shift P left until P[8] = 1, decrementing er per shift (leading-one detect, at most 8 shifts)
//   - mantissa = P[7:4], truncated (no rounding, same as the adder)
//   - if z or P == 0: out = {s, 7'h00}, flags = 00
//   - else if er > 7: out = {s, 7'h7F}, flags = 10
//   - else if er < 1: out = {s, 7'h00}, flags = 01 (e = 0 is never produced except as zero)
//   - else: out = {s, er[2:0], mantissa}, flags = 00
// - sticky |= out_flags on each output transfer; clr_sticky clears it and overrides a same-cycle set.
// - out holds its last value while out_valid = 0. Consumers must qualify out with out_valid.
// - Reset mid-operation: all in-flight data is discarded and no result is emitted for it.
//   The first out_valid after release is exactly 3 enabled cycles after the first new input transfer.
// - The downstream adder ignores sign; sign is still produced here for future signed support.
// TESTING
// 1. 0x38*0x38 (1.5*1.5) -> out 0x42 (2.25 truncated), flags 00, out_valid exactly 3 cycles later.
// 2. Back-to-back stream 0x40*0x20, 0x30*0x30, 0xB0*0x30 -> out 0x30, 0x30, 0xB0 on 3 consecutive cycles.
// 3. 0x7F*0x7F -> 0x7F, flags 10, sticky 10; 0x10*0x10 -> 0x00, flags 01, sticky 11; clr_sticky -> sticky 00.
// 4. Zero and denormal inputs: 0x00*0x5A -> 0x00 flags 00; 0x08*0x30 -> 0x00 flags 01.
// 5. Backpressure: hold out_ready = 0 for 4 cycles with 3 ops in flight -> in_ready = 0 and out stable.
//    Release -> all 3 results in order, none lost or duplicated.
// 6. Assert rst_n low with 2 ops in flight -> out_valid = 0 and out = 0 immediately.
//    No stale result appears after release.

Source files
------------

// File: rtl/float8_mul_pipe.sv
// float8_mul_pipe: 3-stage pipelined minifloat multiplier (unpack, multiply, normalise/pack)
// with a global stall, saturate/flush flags and clearable sticky flags.
module float8_mul_pipe #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4,
   parameter int BIAS  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out,
   output logic [1:0]             out_flags,
   output logic [1:0]             sticky,
   input  logic                   clr_sticky
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int EW = EXP_W + 3;
   localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EMIN = EW'(1);

   logic                    en;
   logic                    v1_q, v2_q, v3_q;
   logic                    s1_q, s2_q, z1_q, z2_q;
   logic [EXP_W-1:0]        ea_q, eb_q;
   logic [SW-1:0]           sa_q, sb_q;
   logic [PW-1:0]           p_q, pn;
   logic signed [EW-1:0]    er_d, er_q, e3, sh;
   logic                    zero, ovf, unf;
   logic [W-1:0]            out_d, out_q;
   logic [1:0]              flags_d, flags_q, sticky_d, sticky_q;

   assign en        = out_ready | ~v3_q;
   assign in_ready  = en;
   assign out_valid = v3_q;
   assign out       = out_q;
   assign out_flags = flags_q;
   assign sticky    = sticky_q;
   assign er_d      = EW'(ea_q) + EW'(eb_q) - EW'(BIAS);
   assign sticky_d  = clr_sticky ? 2'b00 : sticky_q | (flags_q & {2{v3_q & out_ready}});

   // Product binary point sits below P[PW-2]; normalise so the leading one lands there.
   always_comb begin
      sh = '0;
      for (int i = 0; i < PW - 1; i++) if (p_q[i]) sh = EW'(PW - 2 - i);
      pn      = p_q[PW-1] ? p_q >> 1 : p_q << sh;
      e3      = p_q[PW-1] ? er_q + EMIN : er_q - sh;
      zero    = z2_q | ~|p_q;
      ovf     = ~zero & (e3 > EMAX);
      unf     = ~zero & ~ovf & (e3 < EMIN);
      out_d   = (zero | unf) ? {s2_q, {(W-1){1'b0}}} :
                ovf ? {s2_q, {(W-1){1'b1}}} :
                {s2_q, e3[EXP_W-1:0], MAN_W'(pn >> (PW - 2 - MAN_W))};
      flags_d = {ovf, unf};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         z1_q     <= 1'b0;
         z2_q     <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         p_q      <= '0;
         er_q     <= '0;
         out_q    <= '0;
         flags_q  <= '0;
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
         if (en) begin
            v1_q <= in_valid;
            s1_q <= a[W-1] ^ b[W-1];
            z1_q <= ~|a[W-2:0] | ~|b[W-2:0];
            ea_q <= a[MAN_W +: EXP_W];
            eb_q <= b[MAN_W +: EXP_W];
            sa_q <= {|a[W-2:MAN_W], a[MAN_W-1:0]};
            sb_q <= {|b[W-2:MAN_W], b[MAN_W-1:0]};
            v2_q <= v1_q;
            s2_q <= s1_q;
            z2_q <= z1_q;
            er_q <= er_d;
            p_q  <= PW'(sa_q) * PW'(sb_q);
            v3_q <= v2_q;
            if (v2_q) begin
               out_q   <= out_d;
               flags_q <= flags_d;
            end
         end
      end
endmodule

// File: tb/tb_float8_mul_pipe.sv
// tb_float8_mul_pipe: directed and randomized checks of float8_mul_pipe against a
// real-valued reference model with an in-order scoreboard.
module tb_float8_mul_pipe;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, clr_sticky = 1'b0;
   logic [7:0] a = '0, b = '0, out;
   logic [1:0] out_flags, sticky;

   int         checks = 0, errors = 0, n_out = 0, n0;
   logic [9:0] q[$];
   logic [1:0] sticky_m = '0;
   logic [7:0] last_out, held;
   logic [1:0] last_flags;

   float8_mul_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_flags(out_flags),
      .sticky(sticky), .clr_sticky(clr_sticky)
   );

   always #5 clk = ~clk;

   function automatic real val(input logic [7:0] x);
      real v;
      v = ((x[6:4] != 0) ? 1.0 : 0.0) + x[3:0] / 16.0;
      for (int k = 0; k < 3; k++) v = v / 2.0;
      for (int k = 0; k < x[6:4]; k++) v = v * 2.0;
      return v;
   endfunction

   // Returns {flags, result} from the magnitude product and the format's value rules.
   function automatic logic [9:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      real p;
      int  e;
      logic s;
      s = x[7] ^ y[7];
      p = val(x) * val(y);
      if (p == 0.0) return {2'b00, s, 7'h00};
      e = 3;
      while (p >= 2.0) begin p = p / 2.0; e++; end
      while (p < 1.0) begin p = p * 2.0; e--; end
      if (e > 7) return {2'b10, s, 7'h7F};
      if (e < 1) return {2'b01, s, 7'h00};
      return {2'b00, s, 3'(e), 4'($rtoi((p - 1.0) * 16.0))};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ordy, input logic clr);
      logic [9:0] e;
      in_valid = iv; a = ia; b = ib; out_ready = ordy; clr_sticky = clr;
      #1;
      if (in_valid && in_ready) q.push_back(ref_mul(ia, ib));
      if (out_valid && out_ready) begin
         checks++;
         assert (q.size() > 0) else begin
            errors++;
            $error("FAIL spurious_out observed=%0h expected=none", out);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out", out, e[7:0]);
            chk("flags", out_flags, e[9:8]);
            sticky_m = sticky_m | e[9:8];
         end
         last_out = out;
         last_flags = out_flags;
         n_out++;
      end
      if (clr) sticky_m = 2'b00;
      @(posedge clk);
      #1;
      chk("sticky", sticky, sticky_m);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() > 0; k++) cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_flags", out_flags, 0);
      chk("rst_sticky", sticky, 0);
      rst_n = 1'b1;
      #2;
      chk("rst_ready", in_ready, 1);

      // 1.5 * 1.5 with latency measurement
      cyc(1'b1, 8'h38, 8'h38, 1'b1, 1'b0);
      chk("lat1", out_valid, 0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("lat2", out_valid, 0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("lat3", out_valid, 1);
      chk("t1_out", out, 8'h42);
      drain();
      chk("t1_last", last_out, 8'h42);

      // back-to-back stream
      cyc(1'b1, 8'h40, 8'h20, 1'b1, 1'b0);
      cyc(1'b1, 8'h30, 8'h30, 1'b1, 1'b0);
      cyc(1'b1, 8'hB0, 8'h30, 1'b1, 1'b0);
      chk("t2_o1", {out_valid, out}, {1'b1, 8'h30});
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t2_o2", {out_valid, out}, {1'b1, 8'h30});
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t2_o3", {out_valid, out}, {1'b1, 8'hB0});
      drain();

      // saturation, flush, sticky accumulation and clear
      cyc(1'b1, 8'h7F, 8'h7F, 1'b1, 1'b0);
      drain();
      chk("t3_sat", {last_flags, last_out}, {2'b10, 8'h7F});
      chk("t3_st10", sticky, 2'b10);
      cyc(1'b1, 8'h10, 8'h10, 1'b1, 1'b0);
      drain();
      chk("t3_unf", {last_flags, last_out}, {2'b01, 8'h00});
      chk("t3_st11", sticky, 2'b11);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      chk("t3_clr", sticky, 2'b00);

      // zero and denormal operands
      cyc(1'b1, 8'h00, 8'h5A, 1'b1, 1'b0);
      drain();
      chk("t4_zero", {last_flags, last_out}, {2'b00, 8'h00});
      cyc(1'b1, 8'h08, 8'h30, 1'b1, 1'b0);
      drain();
      chk("t4_denorm", {last_flags, last_out}, {2'b01, 8'h00});

      // backpressure with three ops in flight
      n0 = n_out;
      cyc(1'b1, 8'h38, 8'h38, 1'b1, 1'b0);
      cyc(1'b1, 8'h45, 8'h2C, 1'b1, 1'b0);
      cyc(1'b1, 8'hC7, 8'h31, 1'b0, 1'b0);
      held = out;
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 8'h55, 8'h55, 1'b0, 1'b0);
         chk("bp_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
         chk("bp_out", out, held);
      end
      drain();
      chk("bp_count", n_out - n0, 3);

      // reset with two ops in flight
      cyc(1'b1, 8'h38, 8'h38, 1'b1, 1'b0);
      cyc(1'b1, 8'h7F, 8'h7F, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("r_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("r_valid", out_valid, 0);
      chk("r_out", out, 0);
      q.delete();
      sticky_m = 2'b00;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
         chk("r_no_stale", out_valid, 0);
      end
      cyc(1'b1, 8'h30, 8'h30, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("r_lat2", out_valid, 0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("r_lat3", {out_valid, out}, {1'b1, 8'h30});
      drain();

      // randomized traffic with random backpressure and occasional sticky clears
      for (int k = 0; k < 400; k++)
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 30) == 0));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
